// File: rtl/decode_pipe_if.sv
// Fetch/execute-side signal bundle for decode_pipe.
// The slave modport is the decode stage's view; master is the surrounding pipeline's view.
interface decode_pipe_if #(
    parameter int DWIDTH = 32,
    parameter int AWIDTH = 32
);
    logic              valid_i;
    logic              ready_o;
    logic [DWIDTH-1:0] insn_i;
    logic [AWIDTH-1:0] pc_i;
    logic              flush_i;
    logic              valid_o;
    logic              ready_i;
    logic [AWIDTH-1:0] pc_o;
    logic [DWIDTH-1:0] insn_o;
    logic [6:0]        opcode_o;
    logic [4:0]        rd_o;
    logic [2:0]        funct3_o;
    logic [4:0]        rs1_o;
    logic [4:0]        rs2_o;
    logic [4:0]        shamt_o;
    logic [6:0]        funct7_o;
    logic [DWIDTH-1:0] imm_o;
    logic              illegal_o;

    modport slave (
        input  valid_i, insn_i, pc_i, flush_i, ready_i,
        output ready_o, valid_o, pc_o, insn_o, opcode_o, rd_o, funct3_o,
               rs1_o, rs2_o, shamt_o, funct7_o, imm_o, illegal_o
    );

    modport master (
        output valid_i, insn_i, pc_i, flush_i, ready_i,
        input  ready_o, valid_o, pc_o, insn_o, opcode_o, rd_o, funct3_o,
               rs1_o, rs2_o, shamt_o, funct7_o, imm_o, illegal_o
    );
endinterface

// File: rtl/decode_pipe.sv
// Registered RV32I decode stage with a two-entry skid buffer and synchronous flush.
// Define DECODE_ILLEGAL_CHECK_EN to build the unsupported-encoding check behind illegal_o.
module decode_pipe #(
    parameter int                 DWIDTH   = 32,
    parameter int                 AWIDTH   = 32,
    parameter logic [DWIDTH-1:0]  NOP_INSN = 32'h0000_0013
) (
    input  logic          clk,
    input  logic          rst,
    decode_pipe_if.slave  bus
);
    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

    typedef struct packed {
        logic [AWIDTH-1:0] pc;
        logic [DWIDTH-1:0] insn;
        logic [6:0]        opcode;
        logic [4:0]        rd;
        logic [2:0]        funct3;
        logic [4:0]        rs1;
        logic [4:0]        rs2;
        logic [6:0]        funct7;
        logic [DWIDTH-1:0] imm;
`ifdef DECODE_ILLEGAL_CHECK_EN
        logic              illegal;
`endif
    } payload_t;

`ifdef DECODE_ILLEGAL_CHECK_EN
    function automatic logic illegal_chk(input logic [6:0] op, input logic [2:0] f3,
                                         input logic [6:0] f7);
        logic bad;
        bad = 1'b0;
        case (op)
            7'h0F, 7'h17, 7'h37, 7'h6F, 7'h73: bad = 1'b0;
            7'h63: bad = (f3 == 3'd2) || (f3 == 3'd3);
            7'h67: bad = (f3 != 3'd0);
            7'h03: bad = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
            7'h23: bad = (f3 > 3'd2);
            7'h33: bad = ((f7 != 7'h00) && (f7 != 7'h20)) ||
                         ((f7 == 7'h20) && (f3 != 3'd0) && (f3 != 3'd5));
            7'h13: bad = ((f3 == 3'd1) && (f7 != 7'h00)) ||
                         ((f3 == 3'd5) && (f7 != 7'h00) && (f7 != 7'h20));
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction
`endif

    function automatic payload_t decode(input logic [DWIDTH-1:0] insn, input logic [AWIDTH-1:0] pc);
        payload_t   p;
        logic [31:0] imm32;
        p.pc     = pc;
        p.insn   = insn;
        p.opcode = insn[6:0];
        p.rd     = insn[11:7];
        p.funct3 = insn[14:12];
        p.rs1    = insn[19:15];
        p.rs2    = insn[24:20];
        p.funct7 = insn[31:25];
        case (insn[6:0])
            7'h03, 7'h13, 7'h67, 7'h73: imm32 = {{20{insn[31]}}, insn[31:20]};
            7'h23: imm32 = {{20{insn[31]}}, insn[31:25], insn[11:7]};
            7'h63: imm32 = {{19{insn[31]}}, insn[31], insn[7], insn[30:25], insn[11:8], 1'b0};
            7'h37, 7'h17: imm32 = {insn[31:12], 12'b0};
            7'h6F: imm32 = {{11{insn[31]}}, insn[31], insn[19:12], insn[20], insn[30:21], 1'b0};
            default: imm32 = 32'b0;
        endcase
        p.imm = DWIDTH'($signed(imm32));
`ifdef DECODE_ILLEGAL_CHECK_EN
        p.illegal = illegal_chk(insn[6:0], insn[14:12], insn[31:25]);
`endif
        return p;
    endfunction

    state_t   state_q, state_d;
    payload_t m_q, s_q, in_dec, nop_dec;
    logic     accept, emit, clear, load_m, load_s, m_from_s;

    assign in_dec  = decode(bus.insn_i, bus.pc_i);
    assign nop_dec = decode(NOP_INSN, '0);
    assign accept  = bus.valid_i && (state_q != FULL);
    assign emit    = (state_q != EMPTY) && bus.ready_i;

    always_comb begin
        state_d  = state_q;
        clear    = 1'b0;
        load_m   = 1'b0;
        load_s   = 1'b0;
        m_from_s = 1'b0;
        if (bus.flush_i) begin
            state_d = EMPTY;
            clear   = 1'b1;
        end else begin
            case (state_q)
                EMPTY: if (accept) begin
                    state_d = ONE;
                    load_m  = 1'b1;
                end
                ONE: begin
                    if (accept && emit) begin
                        load_m = 1'b1;
                    end else if (accept) begin
                        state_d = FULL;
                        load_s  = 1'b1;
                    end else if (emit) begin
                        state_d = EMPTY;
                    end
                end
                FULL: if (emit) begin
                    state_d  = ONE;
                    m_from_s = 1'b1;
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
            m_q     <= nop_dec;
            s_q     <= nop_dec;
        end else begin
            state_q <= state_d;
            if (clear) begin
                m_q <= nop_dec;
                s_q <= nop_dec;
            end else begin
                if (load_m)   m_q <= in_dec;
                if (m_from_s) m_q <= s_q;
                if (load_s)   s_q <= in_dec;
            end
        end
    end

    // Handshake outputs depend only on the state register, never on ready_i.
    assign bus.ready_o  = (state_q != FULL);
    assign bus.valid_o  = (state_q != EMPTY);
    assign bus.pc_o     = m_q.pc;
    assign bus.insn_o   = m_q.insn;
    assign bus.opcode_o = m_q.opcode;
    assign bus.rd_o     = m_q.rd;
    assign bus.funct3_o = m_q.funct3;
    assign bus.rs1_o    = m_q.rs1;
    assign bus.rs2_o    = m_q.rs2;
    assign bus.shamt_o  = m_q.rs2;
    assign bus.funct7_o = m_q.funct7;
    assign bus.imm_o    = m_q.imm;
`ifdef DECODE_ILLEGAL_CHECK_EN
    assign bus.illegal_o = m_q.illegal;
`else
    assign bus.illegal_o = 1'b0;
`endif
endmodule

// File: tb/tb_decode_pipe.sv
// Directed self-checking bench for decode_pipe: reset, streaming, back-pressure,
// flush in FULL, immediate formats and the optional illegal-encoding check.
module tb_decode_pipe;
    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    decode_pipe_if #(.DWIDTH(32), .AWIDTH(32)) bus ();

    decode_pipe dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive, advance one edge, then settle before sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic v, input logic [31:0] insn, input logic [31:0] pc);
        bus.valid_i = v;
        bus.insn_i  = insn;
        bus.pc_i    = pc;
    endtask

`ifdef DECODE_ILLEGAL_CHECK_EN
    localparam logic ILL_EN = 1'b1;
`else
    localparam logic ILL_EN = 1'b0;
`endif

    initial begin
        logic [31:0] ins;
        rst         = 1'b1;
        bus.flush_i = 1'b0;
        bus.ready_i = 1'b1;
        offer(1'b0, 32'h0, 32'h0);
        tick();
        tick();
        rst = 1'b0;

        // Reset values
        chk("rst_valid",   32'(bus.valid_o),   32'd0);
        chk("rst_ready",   32'(bus.ready_o),   32'd1);
        chk("rst_pc",      bus.pc_o,           32'd0);
        chk("rst_insn",    bus.insn_o,         32'h0000_0013);
        chk("rst_opcode",  32'(bus.opcode_o),  32'h13);
        chk("rst_rd",      32'(bus.rd_o),      32'd0);
        chk("rst_imm",     bus.imm_o,          32'd0);
        chk("rst_illegal", 32'(bus.illegal_o), 32'd0);
        $display("txn reset: valid=%0b ready=%0b insn=%h", bus.valid_o, bus.ready_o, bus.insn_o);

        // Single instruction, one-cycle latency
        offer(1'b1, 32'hFFF0_0093, 32'h100);
        tick();
        offer(1'b0, 32'h0, 32'h0);
        chk("one_valid", 32'(bus.valid_o), 32'd1);
        chk("one_rd",    32'(bus.rd_o),    32'd1);
        chk("one_rs1",   32'(bus.rs1_o),   32'd0);
        chk("one_imm",   bus.imm_o,        32'hFFFF_FFFF);
        chk("one_pc",    bus.pc_o,         32'h100);
        $display("txn single: insn=%h imm=%h pc=%h", bus.insn_o, bus.imm_o, bus.pc_o);
        tick();
        chk("one_drain", 32'(bus.valid_o), 32'd0);

        // Stream of 8 at full throughput: addi x1, x2, i
        for (int i = 0; i < 8; i++) begin
            ins = {12'(i), 5'd2, 3'd0, 5'd1, 7'h13};
            offer(1'b1, ins, 32'h200 + 32'(4 * i));
            tick();
            chk("strm_valid", 32'(bus.valid_o), 32'd1);
            chk("strm_ready", 32'(bus.ready_o), 32'd1);
            chk("strm_insn",  bus.insn_o,       ins);
            chk("strm_imm",   bus.imm_o,        32'(i));
            chk("strm_pc",    bus.pc_o,         32'h200 + 32'(4 * i));
            $display("txn stream %0d: insn=%h pc=%h", i, bus.insn_o, bus.pc_o);
        end
        offer(1'b0, 32'h0, 32'h0);
        tick();
        chk("strm_drain", 32'(bus.valid_o), 32'd0);

        // Back-pressure fills both entries
        bus.ready_i = 1'b0;
        offer(1'b1, 32'h00C0_00EF, 32'h300);
        tick();
        chk("bp_ready1", 32'(bus.ready_o), 32'd1);
        chk("bp_insn1",  bus.insn_o,       32'h00C0_00EF);
        offer(1'b1, 32'hFE00_0EE3, 32'h304);
        tick();
        offer(1'b0, 32'h0, 32'h0);
        chk("bp_full_ready", 32'(bus.ready_o), 32'd0);
        chk("bp_full_valid", 32'(bus.valid_o), 32'd1);
        chk("bp_hold_insn",  bus.insn_o,       32'h00C0_00EF);
        chk("bp_hold_imm",   bus.imm_o,        32'd12);
        $display("txn bp head: insn=%h imm=%h", bus.insn_o, bus.imm_o);
        bus.ready_i = 1'b1;
        tick();
        chk("bp_2nd_insn",  bus.insn_o,       32'hFE00_0EE3);
        chk("bp_2nd_imm",   bus.imm_o,        32'hFFFF_FFFC);
        chk("bp_2nd_pc",    bus.pc_o,         32'h304);
        chk("bp_2nd_valid", 32'(bus.valid_o), 32'd1);
        chk("bp_2nd_ready", 32'(bus.ready_o), 32'd1);
        $display("txn bp tail: insn=%h imm=%h", bus.insn_o, bus.imm_o);
        tick();
        chk("bp_drain", 32'(bus.valid_o), 32'd0);

        // Flush while FULL with a new instruction offered
        bus.ready_i = 1'b0;
        offer(1'b1, 32'h0010_0093, 32'h400);
        tick();
        offer(1'b1, 32'h0020_0093, 32'h404);
        tick();
        chk("fl_full", 32'(bus.ready_o), 32'd0);
        offer(1'b1, 32'h0030_0093, 32'h408);
        bus.flush_i = 1'b1;
        tick();
        bus.flush_i = 1'b0;
        offer(1'b0, 32'h0, 32'h0);
        chk("fl_valid", 32'(bus.valid_o), 32'd0);
        chk("fl_ready", 32'(bus.ready_o), 32'd1);
        chk("fl_insn",  bus.insn_o,       32'h0000_0013);
        chk("fl_pc",    bus.pc_o,         32'd0);
        chk("fl_imm",   bus.imm_o,        32'd0);
        $display("txn flush: valid=%0b ready=%0b insn=%h", bus.valid_o, bus.ready_o, bus.insn_o);
        bus.ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("fl_gone", 32'(bus.valid_o), 32'd0);
        end

        // U and S immediates
        offer(1'b1, 32'h1234_52B7, 32'h500);
        tick();
        chk("u_imm", bus.imm_o,     32'h1234_5000);
        chk("u_rd",  32'(bus.rd_o), 32'd5);
        $display("txn lui: insn=%h imm=%h", bus.insn_o, bus.imm_o);
        offer(1'b1, 32'h00A1_2223, 32'h504);
        tick();
        chk("s_imm",    bus.imm_o,         32'd4);
        chk("s_rs2",    32'(bus.rs2_o),    32'd10);
        chk("s_rs1",    32'(bus.rs1_o),    32'd2);
        chk("s_funct3", 32'(bus.funct3_o), 32'd2);
        $display("txn sw: insn=%h imm=%h", bus.insn_o, bus.imm_o);

        // Illegal-encoding check (constant 0 when not built)
        offer(1'b1, 32'h0000_007F, 32'h600);
        tick();
        chk("ill_op7f", 32'(bus.illegal_o), 32'(ILL_EN));
        chk("op7f_imm", bus.imm_o,          32'd0);
        $display("txn 0x7f: illegal=%0b", bus.illegal_o);
        offer(1'b1, 32'h4000_5033, 32'h604);
        tick();
        chk("ill_sra",    32'(bus.illegal_o), 32'd0);
        chk("sra_funct7", 32'(bus.funct7_o),  32'h20);
        $display("txn sra: illegal=%0b", bus.illegal_o);
        offer(1'b1, 32'h4000_1013, 32'h608);
        tick();
        offer(1'b0, 32'h0, 32'h0);
        chk("ill_slli", 32'(bus.illegal_o), 32'(ILL_EN));
        chk("slli_shamt", 32'(bus.shamt_o), 32'd0);
        chk("slli_valid", 32'(bus.valid_o), 32'd1);
        $display("txn slli-bad: illegal=%0b", bus.illegal_o);
        tick();
        chk("end_drain", 32'(bus.valid_o), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
